// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC scan controller.
package adc_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } adc_state_t;

    // Default configuration.
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_N_CH    = 2;
    localparam int DEF_SCK_DIV = 2;
    localparam int DEF_T_GAP   = 4;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    // Command length: start, sgl, channel index, msbf.
    function automatic int cmd_len(input int ch_w);
        return ch_w + 3;
    endfunction

    // Bits per frame: command, one null bit, then the conversion result.
    function automatic int frame_bits(input int ch_w, input int data_w);
        return cmd_len(ch_w) + 1 + data_w;
    endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Round-robin picker: first set mask bit strictly after i_last, wrapping;
// i_last itself is chosen only when it is the sole set bit.
module adc_ch_pick
    import adc_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] i_mask,
    input  logic [CH_W-1:0] i_last,
    output logic [CH_W-1:0] o_next,
    output logic            o_none
);

    logic [N_CH-1:0] w_rot;
    int              w_idx;

    // Scan from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        o_next = i_last;
        o_none = 1'b1;
        w_idx  = 0;
        w_rot  = '0;
        for (int off = N_CH; off >= 1; off--) begin
            w_idx = (int'(i_last) + off) % N_CH;
            w_rot = i_mask >> w_idx;
            if (w_rot[0]) begin
                o_next = CH_W'(w_idx);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_scan.sv
// SPI ADC scan controller: single-shot or round-robin conversion of enabled
// channels, one result buffered with a valid/ready output.
//
// Result handshake: sample_valid rises when a frame completes and holds
// sample_data/sample_ch stable until a cycle with sample_valid & sample_ready;
// valid drops on the following cycle. No frame starts while valid is high,
// so a result is never overwritten or lost.
module adc_scan
    import adc_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int N_CH    = DEF_N_CH,
    parameter  int SCK_DIV = DEF_SCK_DIV,
    parameter  int T_GAP   = DEF_T_GAP,
    localparam int CH_W    = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_en,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              miso,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output adc_state_t        dbg_state
);

    localparam int CMD_LEN    = cmd_len(CH_W);
    localparam int FRAME_BITS = frame_bits(CH_W, DATA_W);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int CNT_MAX    = (SCK_DIV > T_GAP) ? SCK_DIV : T_GAP;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    adc_state_t        r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              r_phase, w_phase_n;
    logic [BIT_W-1:0]  r_bit, w_bit_n;
    logic [CH_W-1:0]   r_ch;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_sch;
    logic              r_valid;

    logic              w_load;
    logic              w_shift_en;
    logic              w_deliver;
    logic [CH_W-1:0]   w_pick;
    logic              w_none;
    logic              w_div_done;
    logic              w_gap_done;
    logic              w_go_any;
    logic              w_go_auto;
    logic [CMD_LEN-1:0] w_cmd;
    logic [CMD_LEN-1:0] w_cmd_sh;

    adc_ch_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .i_mask (ch_mask),
        .i_last (r_ch),
        .o_next (w_pick),
        .o_none (w_none)
    );

    assign w_div_done = (r_cnt == CNT_W'(SCK_DIV - 1));
    assign w_gap_done = (r_cnt == CNT_W'(T_GAP - 1));
    // start only matters from IDLE; at the end of GAP the block is still busy.
    assign w_go_any   = (auto_en | start) & ~w_none & ~r_valid;
    assign w_go_auto  = auto_en & ~w_none & ~r_valid;

    // Command word MSB first: start, sgl, channel index, msbf.
    assign w_cmd    = {2'b11, r_ch, 1'b1};
    assign w_cmd_sh = w_cmd << r_bit;

    // Next-state and per-cycle strobes of the frame sequencer.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_phase_n  = r_phase;
        w_bit_n    = r_bit;
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_deliver  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go_any) begin
                    w_state_n = S_SETUP;
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_phase_n = 1'b0;
                    w_load    = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_done) begin
                    w_state_n = S_SHIFT;
                    w_cnt_n   = '0;
                    w_phase_n = 1'b0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                // Capture on the first high cycle; command and null bits are skipped.
                if (r_phase && (r_cnt == '0) && (r_bit > BIT_W'(CMD_LEN)))
                    w_shift_en = 1'b1;
                if (w_div_done) begin
                    w_cnt_n = '0;
                    if (!r_phase) begin
                        w_phase_n = 1'b1;
                    end else begin
                        w_phase_n = 1'b0;
                        if (r_bit == BIT_W'(FRAME_BITS - 1))
                            w_state_n = S_HOLD;
                        else
                            w_bit_n = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_div_done) begin
                    w_state_n = S_GAP;
                    w_cnt_n   = '0;
                    w_deliver = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_cnt_n = '0;
                    // Chain straight into the next frame so cs_n stays high exactly T_GAP.
                    if (w_go_auto) begin
                        w_state_n = S_SETUP;
                        w_bit_n   = '0;
                        w_phase_n = 1'b0;
                        w_load    = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_phase <= w_phase_n;
            r_bit   <= w_bit_n;
        end
    end

    // Channel pointer: holds the channel being/last converted; reset so channel 0 is next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ch <= CH_W'(N_CH - 1);
        else if (w_load)
            r_ch <= w_pick;
    end

    // MSB-first assembly; older bits fall off the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_shift <= '0;
        else if (w_shift_en)
            r_shift <= {r_shift[DATA_W-2:0], miso};
    end

    // Output result buffer and its valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_sch   <= '0;
            r_valid <= 1'b0;
        end else if (w_deliver) begin
            r_data  <= r_shift;
            r_sch   <= r_ch;
            r_valid <= 1'b1;
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Pins decode from state registers, so reset drives them idle immediately.
    assign cs_n = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
    assign sck  = (r_state == S_SHIFT) && r_phase;
    assign mosi = ((r_state == S_SETUP) || (r_state == S_SHIFT)) &&
                  (r_bit < BIT_W'(CMD_LEN)) && w_cmd_sh[CMD_LEN-1];

    assign sample_data  = r_data;
    assign sample_ch    = r_sch;
    assign sample_valid = r_valid;
    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;

endmodule
